trap_ctrl: RTL and testbench

Trap sequencer for the machine-mode CSR file: it is the writer side of the CSR file's second write port (`clint_we/waddr/wdata`). It detects ECALL, EBREAK, MRET and enabled timer/external interrupts at the execute stage. It stalls the pipeline, then writes MEPC, MSTATUS and MCAUSE one per cycle. It ends by issuing a one-cycle redirect to MTVEC, or to MEPC for MRET. The CSR file gives its exu write port priority, so this block keeps `hold_o` high for the whole sequence.

---
 rtl/trap_ctrl.sv | 160 ++++++++++++++++
 tb/tb_trap_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer. It detects ECALL/EBREAK/MRET and
// enabled interrupts at execute. It stalls the pipeline and writes
// MEPC/MSTATUS/MCAUSE through the CSR file's second write port, one per
// cycle. It finishes with a one-cycle redirect to MTVEC, or to MEPC for MRET.
module trap_ctrl #(
    parameter logic [31:0] MTVEC_MASK = 32'hFFFF_FFFC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid_i,
    input  logic [31:0] inst_addr_i,
    input  logic        ecall_i,
    input  logic        ebreak_i,
    input  logic        mret_i,
    input  logic        irq_timer_i,
    input  logic        irq_ext_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    input  logic [31:0] mstatus_i,
    output logic        csr_we_o,
    output logic [31:0] csr_waddr_o,
    output logic [31:0] csr_wdata_o,
    output logic        hold_o,
    output logic        int_assert_o,
    output logic [31:0] int_addr_o
);

    localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;
    localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
    localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;

    localparam logic [31:0] CAUSE_ECALL  = 32'd11;
    localparam logic [31:0] CAUSE_EBREAK = 32'd3;
    localparam logic [31:0] CAUSE_EXT    = 32'h8000_000B;
    localparam logic [31:0] CAUSE_TIMER  = 32'h8000_0007;

    typedef enum logic [2:0] {
        IDLE,
        T_MEPC,
        T_MSTATUS,
        T_MCAUSE,
        T_JUMP,
        R_MSTATUS,
        R_JUMP
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] cause_q, cause_d;

    logic        detect;
    logic        isMret;
    logic [31:0] causeSel;
    logic        mie;

    assign mie = mstatus_i[3];

    // Event detection with fixed priority; gated by reset so nothing is seen while in reset
    always_comb begin
        detect   = 1'b0;
        isMret   = 1'b0;
        causeSel = '0;
        if (!rst && state_q == IDLE && inst_valid_i) begin
            if (ecall_i) begin
                detect   = 1'b1;
                causeSel = CAUSE_ECALL;
            end else if (ebreak_i) begin
                detect   = 1'b1;
                causeSel = CAUSE_EBREAK;
            end else if (mret_i) begin
                detect   = 1'b1;
                isMret   = 1'b1;
            end else if (mie && irq_ext_i) begin
                detect   = 1'b1;
                causeSel = CAUSE_EXT;
            end else if (mie && irq_timer_i) begin
                detect   = 1'b1;
                causeSel = CAUSE_TIMER;
            end
        end
    end

    // State register and capture registers; reset abandons any sequence in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            epc_q   <= '0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
        end
    end

    // Next-state logic: trap path walks MEPC/MSTATUS/MCAUSE/JUMP, MRET path walks MSTATUS/JUMP
    always_comb begin
        state_d = state_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        case (state_q)
            IDLE: begin
                if (detect) begin
                    epc_d   = inst_addr_i;
                    cause_d = causeSel;
                    state_d = isMret ? R_MSTATUS : T_MEPC;
                end
            end
            T_MEPC:    state_d = T_MSTATUS;
            T_MSTATUS: state_d = T_MCAUSE;
            T_MCAUSE:  state_d = T_JUMP;
            T_JUMP:    state_d = IDLE;
            R_MSTATUS: state_d = R_JUMP;
            R_JUMP:    state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Moore CSR-write and redirect outputs; hold also covers the detect cycle
    always_comb begin
        csr_we_o     = 1'b0;
        csr_waddr_o  = '0;
        csr_wdata_o  = '0;
        int_assert_o = 1'b0;
        int_addr_o   = '0;
        hold_o       = (state_q != IDLE) | detect;
        case (state_q)
            T_MEPC: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MEPC;
                csr_wdata_o = epc_q;
            end
            T_MSTATUS: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MSTATUS;
                csr_wdata_o = {mstatus_i[31:8], mstatus_i[3], mstatus_i[6:4], 1'b0, mstatus_i[2:0]};
            end
            T_MCAUSE: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MCAUSE;
                csr_wdata_o = cause_q;
            end
            T_JUMP: begin
                int_assert_o = 1'b1;
                int_addr_o   = mtvec_i & MTVEC_MASK;
            end
            R_MSTATUS: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MSTATUS;
                csr_wdata_o = {mstatus_i[31:8], 1'b1, mstatus_i[6:4], mstatus_i[7], mstatus_i[2:0]};
            end
            R_JUMP: begin
                int_assert_o = 1'b1;
                int_addr_o   = mepc_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed bench for trap_ctrl. A schedule-based reference model
// predicts every output on every cycle, and literal expectations pin key cycles.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid_i;
    logic [31:0] inst_addr_i;
    logic        ecall_i, ebreak_i, mret_i;
    logic        irq_timer_i, irq_ext_i;
    logic [31:0] mtvec_i, mepc_i, mstatus_i;
    logic        csr_we_o;
    logic [31:0] csr_waddr_o, csr_wdata_o;
    logic        hold_o, int_assert_o;
    logic [31:0] int_addr_o;

    int testsRun    = 0;
    int testsFailed = 0;
    bit checkEn     = 1'b0;

    always #5 clk = ~clk;

    trap_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .inst_valid_i (inst_valid_i),
        .inst_addr_i  (inst_addr_i),
        .ecall_i      (ecall_i),
        .ebreak_i     (ebreak_i),
        .mret_i       (mret_i),
        .irq_timer_i  (irq_timer_i),
        .irq_ext_i    (irq_ext_i),
        .mtvec_i      (mtvec_i),
        .mepc_i       (mepc_i),
        .mstatus_i    (mstatus_i),
        .csr_we_o     (csr_we_o),
        .csr_waddr_o  (csr_waddr_o),
        .csr_wdata_o  (csr_wdata_o),
        .hold_o       (hold_o),
        .int_assert_o (int_assert_o),
        .int_addr_o   (int_addr_o)
    );

    // Reference model: a queue of pending actions, one consumed per cycle.
    // op 1 = write MEPC, 2 = trap MSTATUS, 3 = write MCAUSE, 4 = jump MTVEC,
    // op 5 = MRET MSTATUS, 6 = jump MEPC.
    typedef struct {
        int          op;
        logic [31:0] val;
    } action_t;

    action_t plan[$];
    int          updKind;
    logic [31:0] updCause;
    int          cmpKind;
    logic [31:0] cmpCause;

    // kind: 0 = trap, 1 = mret
    function automatic bit modelDetect(output int kind, output logic [31:0] cause);
        kind  = 0;
        cause = 32'd0;
        if (rst || !inst_valid_i) return 1'b0;
        if (ecall_i)  begin cause = 32'd11; return 1'b1; end
        if (ebreak_i) begin cause = 32'd3;  return 1'b1; end
        if (mret_i)   begin kind = 1;       return 1'b1; end
        if (mstatus_i[3] && irq_ext_i)   begin cause = 32'h8000_000B; return 1'b1; end
        if (mstatus_i[3] && irq_timer_i) begin cause = 32'h8000_0007; return 1'b1; end
        return 1'b0;
    endfunction

    function automatic logic [31:0] trapStatus(input logic [31:0] m);
        logic [31:0] r;
        r    = m;
        r[7] = m[3];
        r[3] = 1'b0;
        return r;
    endfunction

    function automatic logic [31:0] mretStatus(input logic [31:0] m);
        logic [31:0] r;
        r    = m;
        r[3] = m[7];
        r[7] = 1'b1;
        return r;
    endfunction

    // Model advance on each clock edge
    always @(posedge clk) begin
        if (rst) begin
            plan.delete();
        end else if (plan.size() > 0) begin
            void'(plan.pop_front());
        end else if (modelDetect(updKind, updCause)) begin
            if (updKind == 1) begin
                plan.push_back('{5, 32'd0});
                plan.push_back('{6, 32'd0});
            end else begin
                plan.push_back('{1, inst_addr_i});
                plan.push_back('{2, 32'd0});
                plan.push_back('{3, updCause});
                plan.push_back('{4, 32'd0});
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison of the DUT against the model
    always @(negedge clk) begin
        logic        eWe, eIa, eHold;
        logic [31:0] eAddr, eData, eIaddr;
        if (checkEn) begin
            eWe = 1'b0; eIa = 1'b0; eAddr = '0; eData = '0; eIaddr = '0;
            eHold = (plan.size() > 0) || modelDetect(cmpKind, cmpCause);
            if (plan.size() > 0) begin
                case (plan[0].op)
                    1: begin eWe = 1'b1; eAddr = 32'h341; eData = plan[0].val; end
                    2: begin eWe = 1'b1; eAddr = 32'h300; eData = trapStatus(mstatus_i); end
                    3: begin eWe = 1'b1; eAddr = 32'h342; eData = plan[0].val; end
                    4: begin eIa = 1'b1; eIaddr = mtvec_i & 32'hFFFF_FFFC; end
                    5: begin eWe = 1'b1; eAddr = 32'h300; eData = mretStatus(mstatus_i); end
                    6: begin eIa = 1'b1; eIaddr = mepc_i; end
                    default: ;
                endcase
            end
            checkOutput("model_we",    {31'b0, csr_we_o},     {31'b0, eWe});
            checkOutput("model_waddr", csr_waddr_o,           eAddr);
            checkOutput("model_wdata", csr_wdata_o,           eData);
            checkOutput("model_hold",  {31'b0, hold_o},       {31'b0, eHold});
            checkOutput("model_ia",    {31'b0, int_assert_o}, {31'b0, eIa});
            checkOutput("model_iaddr", int_addr_o,            eIaddr);
        end
    end

    task automatic applyStimulus(input logic r, input logic v, input logic e, input logic eb,
                                 input logic m, input logic ti, input logic ex,
                                 input logic [31:0] pc, input logic [31:0] ms,
                                 input logic [31:0] mt, input logic [31:0] mp);
        @(posedge clk);
        #1;
        rst = r; inst_valid_i = v; ecall_i = e; ebreak_i = eb; mret_i = m;
        irq_timer_i = ti; irq_ext_i = ex; inst_addr_i = pc;
        mstatus_i = ms; mtvec_i = mt; mepc_i = mp;
    endtask

    // Literal expectation at the current negedge
    task automatic expectLit(input string tag, input logic we, input logic [31:0] addr,
                             input logic [31:0] data, input logic ia,
                             input logic [31:0] iaddr, input logic hold);
        checkOutput({tag, "_we"},    {31'b0, csr_we_o},     {31'b0, we});
        checkOutput({tag, "_waddr"}, csr_waddr_o,           addr);
        checkOutput({tag, "_wdata"}, csr_wdata_o,           data);
        checkOutput({tag, "_ia"},    {31'b0, int_assert_o}, {31'b0, ia});
        checkOutput({tag, "_iaddr"}, int_addr_o,            iaddr);
        checkOutput({tag, "_hold"},  {31'b0, hold_o},       {31'b0, hold});
    endtask

    initial begin
        rst = 1'b1; inst_valid_i = 1'b1; ecall_i = 1'b1; ebreak_i = 1'b0; mret_i = 1'b0;
        irq_timer_i = 1'b0; irq_ext_i = 1'b0; inst_addr_i = 32'h0000_0040;
        mstatus_i = 32'h8; mtvec_i = 32'h0000_0403; mepc_i = 32'h0;

        // Reset held three edges with ECALL present: everything quiet
        @(posedge clk);
        #1 checkEn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            expectLit("rst", 0, 0, 0, 0, 0, 0);
        end
        applyStimulus(0, 1, 1, 0, 0, 0, 0, 32'h40, 32'h8, 32'h403, 32'h0);
        @(negedge clk); expectLit("rstrel_det", 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h40, 32'h8, 32'h403, 32'h0);
        repeat (5) @(negedge clk);

        // ECALL at 0x120
        applyStimulus(0, 1, 1, 0, 0, 0, 0, 32'h120, 32'h8, 32'h403, 32'h0);
        @(negedge clk); expectLit("ecall_T",  0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h124, 32'h8, 32'h403, 32'h0);
        @(negedge clk); expectLit("ecall_T1", 1, 32'h341, 32'h120, 0, 0, 1);
        @(negedge clk); expectLit("ecall_T2", 1, 32'h300, 32'h80, 0, 0, 1);
        @(negedge clk); expectLit("ecall_T3", 1, 32'h342, 32'd11, 0, 0, 1);
        @(negedge clk); expectLit("ecall_T4", 0, 0, 0, 1, 32'h400, 1);
        @(negedge clk); expectLit("ecall_T5", 0, 0, 0, 0, 0, 0);

        // MRET returning to 0x124
        applyStimulus(0, 1, 0, 0, 1, 0, 0, 32'h400, 32'h80, 32'h403, 32'h124);
        @(negedge clk); expectLit("mret_T",  0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h404, 32'h80, 32'h403, 32'h124);
        @(negedge clk); expectLit("mret_T1", 1, 32'h300, 32'h88, 0, 0, 1);
        @(negedge clk); expectLit("mret_T2", 0, 0, 0, 1, 32'h124, 1);
        @(negedge clk); expectLit("mret_T3", 0, 0, 0, 0, 0, 0);

        // Both interrupts with MIE=1: external wins
        applyStimulus(0, 1, 0, 0, 0, 1, 1, 32'h200, 32'h8, 32'h403, 32'h124);
        @(negedge clk); expectLit("irq_T",  0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h204, 32'h8, 32'h403, 32'h124);
        @(negedge clk); expectLit("irq_T1", 1, 32'h341, 32'h200, 0, 0, 1);
        @(negedge clk); expectLit("irq_T2", 1, 32'h300, 32'h80, 0, 0, 1);
        @(negedge clk); expectLit("irq_T3", 1, 32'h342, 32'h8000_000B, 0, 0, 1);
        @(negedge clk); expectLit("irq_T4", 0, 0, 0, 1, 32'h400, 1);

        // Both interrupts with MIE=0 for 10 cycles: no activity
        applyStimulus(0, 1, 0, 0, 0, 1, 1, 32'h400, 32'h80, 32'h403, 32'h124);
        repeat (10) begin
            @(negedge clk); expectLit("mie0", 0, 0, 0, 0, 0, 0);
        end

        // ECALL together with timer, MIE=1: ECALL taken, timer stays pending
        applyStimulus(0, 1, 1, 0, 0, 1, 0, 32'h500, 32'h8, 32'h403, 32'h124);
        @(negedge clk); expectLit("ectm_T",  0, 0, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 0, 1, 0, 32'h504, 32'h8, 32'h403, 32'h124);
        @(negedge clk); expectLit("ectm_T1", 1, 32'h341, 32'h500, 0, 0, 1);
        @(negedge clk); expectLit("ectm_T2", 1, 32'h300, 32'h80, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 0, 1, 0, 32'h504, 32'h80, 32'h403, 32'h124);
        @(negedge clk); expectLit("ectm_T3", 1, 32'h342, 32'd11, 0, 0, 1);
        @(negedge clk); expectLit("ectm_T4", 0, 0, 0, 1, 32'h400, 1);
        repeat (5) begin
            @(negedge clk); expectLit("ectm_after", 0, 0, 0, 0, 0, 0);
        end

        // MRET re-enables MIE with timer pending: interrupt taken right after the redirect
        applyStimulus(0, 1, 0, 0, 1, 1, 0, 32'h600, 32'h80, 32'h403, 32'h124);
        @(negedge clk); expectLit("b2b_T",  0, 0, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 0, 1, 0, 32'h604, 32'h80, 32'h403, 32'h124);
        @(negedge clk); expectLit("b2b_T1", 1, 32'h300, 32'h88, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 0, 1, 0, 32'h124, 32'h88, 32'h403, 32'h124);
        @(negedge clk); expectLit("b2b_T2", 0, 0, 0, 1, 32'h124, 1);
        @(negedge clk); expectLit("b2b_T3", 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h128, 32'h88, 32'h403, 32'h124);
        @(negedge clk); expectLit("b2b_T4", 1, 32'h341, 32'h124, 0, 0, 1);
        @(negedge clk); expectLit("b2b_T5", 1, 32'h300, 32'h80, 0, 0, 1);
        @(negedge clk); expectLit("b2b_T6", 1, 32'h342, 32'h8000_0007, 0, 0, 1);
        @(negedge clk); expectLit("b2b_T7", 0, 0, 0, 1, 32'h400, 1);

        // EBREAK cause
        applyStimulus(0, 1, 0, 1, 0, 0, 0, 32'h700, 32'h8, 32'h800, 32'h124);
        @(negedge clk); expectLit("ebrk_T",  0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h704, 32'h8, 32'h800, 32'h124);
        @(negedge clk); expectLit("ebrk_T1", 1, 32'h341, 32'h700, 0, 0, 1);
        @(negedge clk);
        @(negedge clk); expectLit("ebrk_T3", 1, 32'h342, 32'd3, 0, 0, 1);
        @(negedge clk); expectLit("ebrk_T4", 0, 0, 0, 1, 32'h800, 1);

        // Reset during T_MSTATUS abandons the sequence
        applyStimulus(0, 1, 1, 0, 0, 0, 0, 32'h900, 32'h8, 32'h403, 32'h124);
        @(negedge clk); expectLit("rstmid_T",  0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h904, 32'h8, 32'h403, 32'h124);
        @(negedge clk); expectLit("rstmid_T1", 1, 32'h341, 32'h900, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 32'h904, 32'h8, 32'h403, 32'h124);
        @(negedge clk); expectLit("rstmid_T2", 1, 32'h300, 32'h80, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h904, 32'h8, 32'h403, 32'h124);
        @(negedge clk); expectLit("rstmid_T3", 0, 0, 0, 0, 0, 0);
        @(negedge clk); expectLit("rstmid_T4", 0, 0, 0, 0, 0, 0);
        @(negedge clk); expectLit("rstmid_T5", 0, 0, 0, 0, 0, 0);

        @(posedge clk);
        #1 checkEn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
